// File: rtl/cm_link_rx.sv
// CM byte-bus receive framer: brings the Xmega byte strobe into CLK_50, captures
// each byte, and turns checksummed command frames into single SRAM requests.
`timescale 1ns/1ps
module cm_link_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        CLK_50,
    input  logic        RST_n,
    input  logic [7:0]  CM,
    input  logic        CLK_inter,
    output logic [7:0]  raw_byte,
    output logic        raw_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_we,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  o_dbg_state
);

    // Request handshake: a request transfers on any cycle where cmd_valid and
    // cmd_ready are both high; once cmd_valid rises, it and cmd_we/cmd_addr/
    // cmd_data hold unchanged until that transfer cycle.

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OVERRUN  = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR_H = 3'd2,
        S_ADDR_L = 3'd3,
        S_DATA   = 3'd4,
        S_CSUM   = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    logic             r_inter_s1;
    logic             r_inter_s2;
    logic             r_inter_s3;
    logic [7:0]       r_cm_s1;
    logic [7:0]       r_cm_s2;
    logic [7:0]       r_raw_byte;
    logic             r_raw_valid;

    state_t           r_state;
    logic             r_we;
    logic [7:0]       r_addr_h;
    logic [7:0]       r_addr_l;
    logic [7:0]       r_data;
    logic [7:0]       r_xor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_valid;
    logic             r_err;
    logic [1:0]       r_err_code;

    state_t           w_state_nxt;
    logic             w_we_nxt;
    logic [7:0]       w_addr_h_nxt;
    logic [7:0]       w_addr_l_nxt;
    logic [7:0]       w_data_nxt;
    logic [7:0]       w_xor_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cmd_valid_nxt;
    logic             w_err_nxt;
    logic [1:0]       w_err_code_nxt;

    logic             w_edge;
    logic [7:0]       w_byte;
    logic             w_in_frame;

    // CM is only sampled on the strobe edge, by which time it has been stable
    // long enough that the two-flop copy aligned with s2 is a clean byte.
    assign w_edge     = r_inter_s2 & ~r_inter_s3;
    assign w_byte     = r_cm_s2;
    assign w_in_frame = r_state inside {S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_CSUM};

    always_ff @(posedge CLK_50 or negedge RST_n) begin
        if (!RST_n) begin
            r_inter_s1  <= 1'b0;
            r_inter_s2  <= 1'b0;
            r_inter_s3  <= 1'b0;
            r_cm_s1     <= 8'h00;
            r_cm_s2     <= 8'h00;
            r_raw_byte  <= 8'h00;
            r_raw_valid <= 1'b0;
        end else begin
            r_inter_s1  <= CLK_inter;
            r_inter_s2  <= r_inter_s1;
            r_inter_s3  <= r_inter_s2;
            r_cm_s1     <= CM;
            r_cm_s2     <= r_cm_s1;
            r_raw_valid <= w_edge;
            if (w_edge) begin
                r_raw_byte <= w_byte;
            end
        end
    end

    always_ff @(posedge CLK_50 or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr_h    <= 8'h00;
            r_addr_l    <= 8'h00;
            r_data      <= 8'h00;
            r_xor       <= 8'h00;
            r_cnt       <= '0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_addr_h    <= w_addr_h_nxt;
            r_addr_l    <= w_addr_l_nxt;
            r_data      <= w_data_nxt;
            r_xor       <= w_xor_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = r_we;
        w_addr_h_nxt    = r_addr_h;
        w_addr_l_nxt    = r_addr_l;
        w_data_nxt      = r_data;
        w_xor_nxt       = r_xor;
        w_cnt_nxt       = '0;
        w_cmd_valid_nxt = r_cmd_valid;
        w_err_nxt       = 1'b0;
        w_err_code_nxt  = 2'd0;

        // A byte on the same cycle as expiry wins: the byte path below runs and
        // the counter stays at its cleared default.
        if (w_in_frame && !w_edge) begin
            if (r_cnt == CNT_LAST) begin
                w_err_nxt      = 1'b1;
                w_err_code_nxt = ERR_TIMEOUT;
                w_state_nxt    = S_IDLE;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_edge && (w_byte == SYNC_BYTE)) begin
                    w_xor_nxt   = 8'h00;
                    w_data_nxt  = 8'h00;
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (w_edge) begin
                    if (w_byte == CMD_WRITE || w_byte == CMD_READ) begin
                        w_we_nxt    = (w_byte == CMD_WRITE);
                        w_xor_nxt   = r_xor ^ w_byte;
                        w_state_nxt = S_ADDR_H;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_BAD_CMD;
                        w_state_nxt    = S_IDLE;
                    end
                end
            end
            S_ADDR_H: begin
                if (w_edge) begin
                    w_addr_h_nxt = w_byte;
                    w_xor_nxt    = r_xor ^ w_byte;
                    w_state_nxt  = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (w_edge) begin
                    w_addr_l_nxt = w_byte;
                    w_xor_nxt    = r_xor ^ w_byte;
                    w_state_nxt  = r_we ? S_DATA : S_CSUM;
                end
            end
            S_DATA: begin
                if (w_edge) begin
                    w_data_nxt  = w_byte;
                    w_xor_nxt   = r_xor ^ w_byte;
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_edge) begin
                    if (w_byte == r_xor) begin
                        w_cmd_valid_nxt = 1'b1;
                        w_state_nxt     = S_HOLD;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_CHECKSUM;
                        w_state_nxt    = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (r_cmd_valid && cmd_ready) begin
                    w_cmd_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
                // The pending request is never disturbed; an incoming byte is dropped.
                if (w_edge) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_OVERRUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign raw_byte    = r_raw_byte;
    assign raw_valid   = r_raw_valid;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_we      = r_we;
    assign cmd_addr    = {r_addr_h, r_addr_l};
    assign cmd_data    = r_data;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cm_link_rx.sv
// Bench for cm_link_rx: directed frames plus random byte streams, scored against
// a frame-level stream parser.
`timescale 1ns/1ps
module tb_cm_link_rx;

  localparam int         T_CYC = 100;
  localparam logic [7:0] SYNC  = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic        CLK_50 = 1'b0;
  logic        RST_n;
  logic [7:0]  CM;
  logic        CLK_inter;
  logic        cmd_ready;
  logic [7:0]  raw_byte;
  logic        raw_valid;
  logic        cmd_valid;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  cm_link_rx #(.TIMEOUT_CYCLES(T_CYC), .SYNC_BYTE(SYNC)) dut (
    .CLK_50(CLK_50), .RST_n(RST_n), .CM(CM), .CLK_inter(CLK_inter),
    .raw_byte(raw_byte), .raw_valid(raw_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .err(err), .err_code(err_code), .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 CLK_50 = ~CLK_50;

  int cyc = 0;
  always @(posedge CLK_50) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard queues
  logic [7:0]  exp_raw_q[$];
  logic [7:0]  obs_raw_q[$];
  logic [24:0] exp_cmd_q[$];
  logic [24:0] obs_cmd_q[$];
  logic [1:0]  exp_err_q[$];
  logic [1:0]  obs_err_q[$];
  bq_t         sent_q;

  int          last_raw_cyc  = -100;
  int          last_rise_cyc = 0;
  int          cmd_rise_cyc  = -1;
  int          err_cyc       = -1;
  int          stab_err      = 0;
  logic        prev_valid    = 1'b0;
  logic [24:0] prev_payload  = '0;
  logic [24:0] payload;

  assign payload = {cmd_we, cmd_addr, cmd_data};

  always @(negedge CLK_50) begin
    if (raw_valid) begin
      obs_raw_q.push_back(raw_byte);
      last_raw_cyc = cyc;
    end
    if (cmd_valid && !prev_valid) cmd_rise_cyc = cyc;
    if (cmd_valid && prev_valid && payload != prev_payload) stab_err++;
    if (cmd_valid && cmd_ready) obs_cmd_q.push_back(payload);
    if (err) begin
      obs_err_q.push_back(err_code);
      err_cyc = cyc;
    end
    prev_valid   = cmd_valid;
    prev_payload = payload;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(posedge CLK_50); #1 CM = b;
    repeat (4) @(posedge CLK_50);
    #1 CLK_inter = 1'b1;
    last_rise_cyc = cyc;
    repeat (hi) @(posedge CLK_50);
    #1 CLK_inter = 1'b0;
    repeat (lo) @(posedge CLK_50);
    sent_q.push_back(b);
    check("raw_latency", ((last_raw_cyc - last_rise_cyc) >= 3) && ((last_raw_cyc - last_rise_cyc) <= 4), 1);
  endtask

  task automatic send_list(input bq_t q, input int fixed);
    foreach (q[i]) begin
      if (fixed > 0) send_byte(q[i], fixed, fixed);
      else send_byte(q[i], $urandom_range(3, 8), $urandom_range(3, 8));
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    do begin
      @(negedge CLK_50);
      k++;
    end while (!cmd_valid && k < 200);
    check({tag, "_valid_seen"}, cmd_valid, 1);
  endtask

  // reference: frame-level parser over the byte stream sent since the last call
  task automatic model_run();
    int n;
    int i;
    int flen;
    logic [7:0] c;
    logic [7:0] x;
    n = sent_q.size();
    i = 0;
    foreach (sent_q[j]) exp_raw_q.push_back(sent_q[j]);
    while (i < n) begin
      if (sent_q[i] != SYNC) begin
        i++;
      end else if (i + 1 >= n) begin
        exp_err_q.push_back(2'd3);
        i = n;
      end else begin
        c = sent_q[i+1];
        if (c != 8'h01 && c != 8'h02) begin
          exp_err_q.push_back(2'd1);
          i += 2;
        end else begin
          flen = (c == 8'h01) ? 6 : 5;
          if (i + flen > n) begin
            exp_err_q.push_back(2'd3);
            i = n;
          end else begin
            x = 8'h00;
            for (int k = 1; k < flen - 1; k++) x ^= sent_q[i+k];
            if (x == sent_q[i+flen-1])
              exp_cmd_q.push_back({c == 8'h01, sent_q[i+2], sent_q[i+3],
                                   (c == 8'h01) ? sent_q[i+4] : 8'h00});
            else
              exp_err_q.push_back(2'd2);
            i += flen;
          end
        end
      end
    end
    sent_q.delete();
  endtask

  task automatic compare_sb(input string tag);
    check({tag, "_n_raw"}, obs_raw_q.size(), exp_raw_q.size());
    for (int i = 0; i < exp_raw_q.size() && i < obs_raw_q.size(); i++)
      check({tag, "_raw"}, obs_raw_q[i], exp_raw_q[i]);
    check({tag, "_n_cmd"}, obs_cmd_q.size(), exp_cmd_q.size());
    for (int i = 0; i < exp_cmd_q.size() && i < obs_cmd_q.size(); i++)
      check({tag, "_cmd"}, obs_cmd_q[i], exp_cmd_q[i]);
    check({tag, "_n_err"}, obs_err_q.size(), exp_err_q.size());
    for (int i = 0; i < exp_err_q.size() && i < obs_err_q.size(); i++)
      check({tag, "_err_code"}, obs_err_q[i], exp_err_q[i]);
    check({tag, "_stable"}, stab_err, 0);
    exp_raw_q.delete(); obs_raw_q.delete();
    exp_cmd_q.delete(); obs_cmd_q.delete();
    exp_err_q.delete(); obs_err_q.delete();
    stab_err = 0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    bq_t        f;
    int         held;
    int         kind;
    logic [7:0] c;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] d;
    logic [7:0] x;

    CM = 8'h00; CLK_inter = 1'b0; cmd_ready = 1'b1; RST_n = 1'b0;
    repeat (3) @(negedge CLK_50);
    check("rst_outputs", {raw_byte, raw_valid, cmd_valid, cmd_we, cmd_addr, cmd_data, err, err_code}, 0);
    @(posedge CLK_50); #1 RST_n = 1'b1;
    repeat (5) @(posedge CLK_50);

    // write frame, 10-cycle strobes
    f = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h5A, 8'h7D};
    send_list(f, 10);
    repeat (20) @(negedge CLK_50);
    check("wr_valid_rise_cycle", cmd_rise_cyc, last_raw_cyc);
    model_run();
    compare_sb("wr");

    // read frame under 20 cycles of backpressure
    @(posedge CLK_50); #1 cmd_ready = 1'b0;
    f = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h12};
    send_list(f, 0);
    wait_valid("rd");
    held = 0;
    repeat (20) begin
      @(negedge CLK_50);
      held += int'(cmd_valid);
    end
    check("rd_held", held, 20);
    check("rd_we", cmd_we, 0);
    check("rd_addr", cmd_addr, 16'h0010);
    check("rd_data", cmd_data, 8'h00);
    @(posedge CLK_50); #1 cmd_ready = 1'b1;
    @(negedge CLK_50);
    check("rd_valid_hs_cycle", cmd_valid, 1);
    @(negedge CLK_50);
    check("rd_valid_cleared", cmd_valid, 0);
    model_run();
    compare_sb("rd");

    // checksum error followed by a good frame
    f = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h5A, 8'h00, 8'hA5, 8'h02, 8'h00, 8'h10, 8'h12};
    send_list(f, 0);
    repeat (20) @(negedge CLK_50);
    model_run();
    compare_sb("csum");

    // idle noise and bad command
    f = {8'h33, 8'hA5, 8'h07};
    send_list(f, 0);
    repeat (20) @(negedge CLK_50);
    model_run();
    compare_sb("badcmd");

    // inter-byte timeout
    f = {8'hA5, 8'h01, 8'h12};
    send_list(f, 0);
    repeat (T_CYC + 50) @(negedge CLK_50);
    check("to_latency", err_cyc - last_raw_cyc, T_CYC);
    model_run();
    compare_sb("to");

    // overrun while a request is pending
    @(posedge CLK_50); #1 cmd_ready = 1'b0;
    f = {8'hA5, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h88};
    send_list(f, 0);
    wait_valid("ovr");
    model_run();
    send_byte(8'h55, 4, 4);
    sent_q.delete();
    exp_raw_q.push_back(8'h55);
    exp_err_q.push_back(2'd0);
    @(negedge CLK_50);
    check("ovr_raw_byte", raw_byte, 8'h55);
    check("ovr_still_valid", cmd_valid, 1);
    check("ovr_payload", payload, {1'b1, 16'hABCD, 8'hEF});
    @(posedge CLK_50); #1 cmd_ready = 1'b1;
    repeat (5) @(negedge CLK_50);
    compare_sb("ovr");

    // reset in the middle of a frame
    f = {8'hA5, 8'h02, 8'h77};
    send_list(f, 0);
    foreach (f[i]) exp_raw_q.push_back(f[i]);
    sent_q.delete();
    @(posedge CLK_50); #3 RST_n = 1'b0;
    #1 check("rst_mid_outputs", {raw_byte, raw_valid, cmd_valid, cmd_we, cmd_addr, cmd_data, err, err_code}, 0);
    @(posedge CLK_50); #1 RST_n = 1'b1;
    repeat (T_CYC + 50) @(negedge CLK_50);
    compare_sb("rst");
    f = {8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
    send_list(f, 0);
    repeat (20) @(negedge CLK_50);
    model_run();
    compare_sb("rst_recover");

    // random streams of good, corrupted, bad-command and noise items
    for (int s = 0; s < 6; s++) begin
      for (int it = 0; it < 8; it++) begin
        kind = $urandom_range(0, 5);
        a1 = 8'($urandom_range(0, 255));
        a2 = 8'($urandom_range(0, 255));
        d  = 8'($urandom_range(0, 255));
        if (kind <= 3) begin
          c = (kind == 2) ? 8'h02 : (kind == 3 ? 8'($urandom_range(1, 2)) : 8'h01);
          x = c ^ a1 ^ a2 ^ ((c == 8'h01) ? d : 8'h00);
          if (kind == 3) x = x ^ 8'($urandom_range(1, 255));
          if (c == 8'h01) f = {SYNC, c, a1, a2, d, x};
          else            f = {SYNC, c, a1, a2, x};
        end else if (kind == 4) begin
          do c = 8'($urandom_range(0, 255)); while (c == 8'h01 || c == 8'h02);
          f = {SYNC, c};
        end else begin
          f = {d};
        end
        send_list(f, 0);
      end
      repeat (T_CYC + 50) @(negedge CLK_50);
      model_run();
      compare_sb("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cm_link_rx.md
# cm_link_rx

Receive-side framer for the 8-bit CM chip-interconnect bus from the Xmega. It resynchronises the asynchronous CLK_inter byte strobe into the CLK_50 domain, captures each CM byte, and assembles checksummed command frames into single SRAM read/write requests. It sits between the CM pins at top level and the SRAM controller. A raw-byte tap keeps the LED byte display working.

## Interface
- TIMEOUT_CYCLES, 50000: CLK_50 cycles allowed between bytes inside a frame (1 ms) before the frame is aborted.
- SYNC_BYTE, 8'hA5: frame start marker.
- CLK_50  in  1  system clock, 50 MHz.
- RST_n  in  1  reset; one clock; reset is asynchronous and active-low.
- CM  in  8  byte bus from the Xmega, asynchronous to CLK_50.
- CLK_inter  in  1  byte strobe from the Xmega (PC0). A rising edge means CM holds a new byte. Asynchronous.
- raw_byte  out  8  last captured CM byte, for the LED display.
- raw_valid  out  1  1-cycle pulse when raw_byte updates.
- cmd_valid  out  1  request valid; held until accepted.
- cmd_ready  in  1  SRAM controller accepts the request.
- cmd_we  out  1  1 = write (cmd 0x01), 0 = read (cmd 0x02).
- cmd_addr  out  16  SRAM address, {addr_h, addr_l}.
- cmd_data  out  8  write data; 8'h00 for reads.
- err  out  1  1-cycle error pulse.
- err_code  out  2  error cause, valid while err is high: 0 overrun, 1 bad cmd, 2 checksum, 3 timeout.

## Operation
- **Synchronisation.**
  - CLK_inter passes through three flops s1→s2→s3. The byte edge is s2 & ~s3.
  - CM passes through two flops, aligned with s2.
  - On the edge cycle, the synced CM is captured.
- **Frame format.**
  - Write: SYNC, CMD, ADDR_H, ADDR_L, DATA, CSUM.
  - Read: SYNC, CMD, ADDR_H, ADDR_L, CSUM.
  - CSUM is the XOR of every byte after SYNC and before CSUM.
- **FSM states:** IDLE, CMD, ADDR_H, ADDR_L, DATA, CSUM, HOLD.
  - IDLE: byte == SYNC_BYTE → CMD. Any other byte is ignored, with no error.
  - CMD: 0x01 → ADDR_H with we=1. 0x02 → ADDR_H with we=0. Any other value → err code 1, then IDLE.
  - ADDR_H → ADDR_L.
  - ADDR_L → DATA if we, else → CSUM.
  - DATA → CSUM.
  - CSUM: match → HOLD and assert cmd_valid. Mismatch → err code 2, then IDLE.
  - HOLD: cmd_valid & cmd_ready → IDLE, cmd_valid deasserts. A byte arriving in HOLD is discarded with err code 0; the state stays HOLD.
- **Running XOR.** Cleared on entry to CMD; accumulates CMD through DATA.
- **Timeout counter.**
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Runs only in CMD, ADDR_H, ADDR_L, DATA and CSUM; cleared on every byte and in IDLE/HOLD.
  - When it reaches TIMEOUT_CYCLES: err code 3, then IDLE.
- **Raw tap.** raw_byte and raw_valid update on every captured byte, in every state, including discarded bytes.
- **Simultaneous events.**
  - A byte and the timeout in the same cycle: the byte wins and the counter clears.
  - An overrun byte on the same cycle as the handshake: the handshake completes, the byte is discarded, err code 0.
- **Reset.** Reset mid-frame returns to IDLE. The partial frame is lost and no err is raised.

## Timing
- Reset values:
  - outputs: raw_byte=0, raw_valid=0, cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_data=0, err=0, err_code=0;
  - internal: sync flops=0, state=IDLE, counter=0.
- CLK_inter must stay high ≥3 and low ≥3 CLK_50 cycles.
- CM must be stable ≥3 cycles before the CLK_inter rise and until its fall.
- Latency from the CLK_inter rise to the raw_valid pulse is 3–4 CLK_50 edges.
- cmd_valid rises the cycle after the CSUM edge cycle.
- cmd_we, cmd_addr and cmd_data are stable whenever cmd_valid=1.
- err and raw_valid are registered and last exactly one cycle.

## Test plan
- **Write frame.** A5 01 12 34 5A 7D, strobes 10 cycles high/low, cmd_ready=1. Expect:
  - one cmd_valid pulse with we=1, addr=16'h1234, data=8'h5A;
  - six raw_valid pulses;
  - no err.
- **Read frame with backpressure.** A5 02 00 10 12, cmd_ready held 0 for 20 cycles. Expect cmd_valid held for 20 cycles with we=0, addr=16'h0010, data=8'h00, and clearing one cycle after ready rises.
- **Checksum error.** A5 01 12 34 5A 00. Expect err with err_code=2, no cmd_valid, return to IDLE. A following valid frame is accepted.
- **Bad command and idle noise.** 33 A5 07. Expect:
  - 33 is ignored silently;
  - 07 gives err_code=1;
  - three raw_valid pulses.
- **Timeout.** A5 01 12, then silence. Expect err_code=3 exactly TIMEOUT_CYCLES cycles after the 12 byte edge. Use TIMEOUT_CYCLES=100 in the bench.
- **Overrun and reset.**
  - During HOLD, send byte 55. Expect err_code=0, request unchanged, raw_byte=55.
  - Assert RST_n low mid-frame. Expect all outputs 0 immediately.
